// File: rtl/cond_exec_stage.sv
// ---------------------------------------------------------------------------
// cond_exec_stage
//
// Execute-stage conditional unit of the pipelined ARM core. It holds the
// Decode->Execute control register and the architectural NZCV flag register.
// The condition field of the instruction in Execute is checked against the
// stored flags. The result gates that instruction's register write, memory
// write, PC write, branch and flag update. Two counters record how many
// instructions were retired and how many were squashed.
//
// Ports
//   CLK, Reset          clock, synchronous active-high reset
//   StallE, FlushE      hold / bubble the E register (flush has priority)
//   ValidD, CondD       Decode slot valid flag and condition field [31:28]
//   PCSD, RegWD, MemWD, BranchD, FlagWD
//                       ungated Decode control signals (FlagWD = {NZ, CV})
//   ALUFlags            {N,Z,C,V} from the ALU for the instruction in E
//   ValidE, CondExE     E slot valid flag, condition passed
//   PCSrcE, RegWriteE, MemWriteE, BranchTakenE
//                       condition-gated controls
//   Flags               architectural {N,Z,C,V}
//   RetiredCount, SquashedCount
//                       performance counters, CNTW bits, wrap on overflow
// ---------------------------------------------------------------------------
module cond_exec_stage #(
    parameter int CNTW = 32
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            ValidD,
    input  logic [3:0]      CondD,
    input  logic            PCSD,
    input  logic            RegWD,
    input  logic            MemWD,
    input  logic            BranchD,
    input  logic [1:0]      FlagWD,
    input  logic [3:0]      ALUFlags,
    output logic            ValidE,
    output logic            CondExE,
    output logic            PCSrcE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            BranchTakenE,
    output logic [3:0]      Flags,
    output logic [CNTW-1:0] RetiredCount,
    output logic [CNTW-1:0] SquashedCount
);

    logic            vld_p1;
    logic [3:0]      cond_p1;
    logic            pcs_p1;
    logic            regw_p1;
    logic            memw_p1;
    logic            branch_p1;
    logic [1:0]      flagw_p1;
    logic [3:0]      flags_q;
    logic [CNTW-1:0] retired_q;
    logic [CNTW-1:0] squashed_q;
    logic            pass;
    logic            leave;

    // ARM condition decode; flags are {N,Z,C,V}. Code 1111 never executes.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic r;
        {n, z, c, v} = nzcv;
        case (cond)
            4'b0000: r = z;
            4'b0001: r = !z;
            4'b0010: r = c;
            4'b0011: r = !c;
            4'b0100: r = n;
            4'b0101: r = !n;
            4'b0110: r = v;
            4'b0111: r = !v;
            4'b1000: r = !z && c;
            4'b1001: r = z || !c;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = !z && (n == v);
            4'b1101: r = z || (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // ---- Decode -> Execute register ----
    always_ff @(posedge CLK) begin
        if (Reset || FlushE) begin
            vld_p1    <= 1'b0;
            cond_p1   <= 4'b0000;
            pcs_p1    <= 1'b0;
            regw_p1   <= 1'b0;
            memw_p1   <= 1'b0;
            branch_p1 <= 1'b0;
            flagw_p1  <= 2'b00;
        end else if (!StallE) begin
            vld_p1    <= ValidD;
            cond_p1   <= CondD;
            pcs_p1    <= PCSD;
            regw_p1   <= RegWD;
            memw_p1   <= MemWD;
            branch_p1 <= BranchD;
            flagw_p1  <= FlagWD;
        end
    end

    // ---- Execute: condition check and gating ----
    assign pass  = vld_p1 && cond_eval(cond_p1, flags_q);
    // The instruction in E commits its side effects only on the edge where
    // it actually moves on; a flush does not prevent that, a stall does.
    assign leave = !StallE;

    assign ValidE       = vld_p1;
    assign CondExE      = pass;
    assign PCSrcE       = pcs_p1 && pass;
    assign RegWriteE    = regw_p1 && pass;
    assign MemWriteE    = memw_p1 && pass;
    assign BranchTakenE = branch_p1 && pass;
    assign Flags        = flags_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            flags_q <= 4'b0000;
        end else if (pass && leave) begin
            if (flagw_p1[1]) flags_q[3:2] <= ALUFlags[3:2];
            if (flagw_p1[0]) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            retired_q  <= '0;
            squashed_q <= '0;
        end else if (vld_p1 && leave) begin
            if (pass) retired_q  <= retired_q + CNTW'(1);
            else      squashed_q <= squashed_q + CNTW'(1);
        end
    end

    assign RetiredCount  = retired_q;
    assign SquashedCount = squashed_q;

endmodule

// File: doc/cond_exec_stage.md
# cond_exec_stage

Execute-stage conditional unit of the pipelined ARM core. Holds the D→E control pipeline register and the architectural NZCV flag register. Evaluates the 4-bit condition field of the instruction in Execute against the stored flags and gates that instruction's side effects: register write, memory write, PC write, branch and flag update. Also maintains retired and squashed instruction counters for performance monitoring.

## Interface
Parameters:
- CNTW, 32, width of the RetiredCount and SquashedCount counters.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- StallE  in  1  holds the E register, flags and counters.
- FlushE  in  1  loads a bubble into E; takes priority over StallE.
- ValidD  in  1  the Decode slot holds a real instruction.
- CondD  in  4  condition field, bits [31:28].
- PCSD, RegWD, MemWD, BranchD  in  1 each  ungated Decode control signals.
- FlagWD  in  2  bit1 enables the N,Z update; bit0 enables the C,V update.
- ALUFlags  in  4  {N,Z,C,V} produced by the ALU for the instruction in E.
- ValidE  out  1  the E slot holds a real instruction.
- CondExE  out  1  condition passed; forced 0 when ValidE=0.
- PCSrcE, RegWriteE, MemWriteE, BranchTakenE  out  1 each  gated controls.
- Flags  out  4  architectural {N,Z,C,V}.
- RetiredCount, SquashedCount  out  CNTW each.

## Operation
- E register contents: ValidE, CondE, PCSE, RegWE, MemWE, BranchE and FlagWE.
- Update priority for the E register: Reset, then FlushE, then StallE, then load.
  - Reset or FlushE: all E fields cleared to 0.
  - StallE alone: all E fields hold.
  - Otherwise: the E fields load the D inputs.
- Condition evaluation is combinational from CondE and the registered Flags:
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: !Z&C. 1001 LS: Z|!C.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1.
  - 1111: 0 (never). The decode must be complete so no latch is inferred.
- Let Pass = ValidE & cond_result. Then:
  - CondExE = Pass.
  - PCSrcE = PCSE & Pass.
  - RegWriteE = RegWE & Pass.
  - MemWriteE = MemWE & Pass.
  - BranchTakenE = BranchE & Pass.
- Flag write fires only when the instruction leaves E: Pass & !StallE & !Reset.
  - If FlagWE[1] is set: Flags[3:2] <= ALUFlags[3:2].
  - If FlagWE[0] is set: Flags[1:0] <= ALUFlags[1:0].
  - A FlushE in the same cycle does not block a flag write by the departing instruction.
- Counters update only when ValidE & !StallE & !Reset:
  - If Pass, RetiredCount increments by 1.
  - Otherwise, SquashedCount increments by 1.
  - Both counters wrap modulo 2^CNTW; they never saturate.
- The block does not flush itself. The hazard unit consumes BranchTakenE and drives FlushE and FlushD.

## Timing
- Reset values: every E field = 0, Flags = 4'b0000, both counters = 0. Therefore every output is 0 after reset.
- Latency:
  - An instruction presented in D at edge n is in E after edge n.
  - Its gated outputs are valid combinationally during cycle n+1.
  - Its flag update is visible from edge n+1.
- Back-to-back dependency: an instruction in E sees the flags written by the immediately preceding instruction, with no bubble and no forwarding path.
- Stall:
  - Outputs stay stable for the whole stall.
  - Flags are not written, so the condition result cannot flip mid-stall.
  - Counters do not double-count.
- Simultaneous StallE and FlushE:
  - E is bubbled.
  - The departing instruction's flag write is blocked by StallE.
- Reset mid-stream: Reset wins over every other input on the same edge, including a pending flag write.

## Test plan
- Reset, then present ADDS with FlagWD=11, CondD=1110 and ALUFlags=0110. Required: Flags=0110 one cycle later; RetiredCount=1.
- Flags=0100 (Z=1); issue BEQ (CondD=0000, BranchD=1, PCSD=1). Required: BranchTakenE=1, PCSrcE=1. Then issue BNE: BranchTakenE=0 and SquashedCount increments.
- Flags=1000; issue STR with CondD=1011 (LT). Required: MemWriteE=1. Then flags=1001 with CondD=1011: MemWriteE=0.
- CMP (FlagWD=11, ALUFlags=0010) immediately followed by ADDHI (CondD=1000, RegWD=1). Required: RegWriteE=1 on the ADDHI cycle.
- Hold StallE for 3 cycles on an instruction with FlagWD=10. Required: Flags and counters unchanged during the stall; exactly one update on release. Also assert StallE+FlushE together: ValidE=0 next cycle and no flag write.
- Preload RetiredCount to all-ones via a CNTW=4 build (15 retires), then one more retire. Required: RetiredCount=0. Separately, CondD=1111 gives CondExE=0.
